// File: rtl/fill_mem_responder.sv
// fill_mem_responder: memory-side responder for the cache fill path.
// Serves single-word reads and writes, and block-aligned burst reads that stream a whole
// cache block back one beat per cycle. Read beats travel a fixed-latency, non-stalling shift
// pipe and are tagged with their word offset inside the block.
module fill_mem_responder #(
   parameter int unsigned Latency  = 4,
   parameter int unsigned BurstLen = 8,
   parameter int unsigned MemLog2  = 15
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic                        req_wr_i,
   input  logic                        req_burst_i,
   input  logic [15:0]                 req_addr_i,
   input  logic [15:0]                 req_data_i,
   output logic                        resp_valid_o,
   output logic [15:0]                 resp_data_o,
   output logic [$clog2(BurstLen)-1:0] resp_offset_o,
   output logic                        resp_last_o,
   output logic                        busy_o
);

   localparam int unsigned OffW  = $clog2(BurstLen);
   localparam int unsigned BlkW  = MemLog2 - OffW;
   localparam int unsigned Words = 2 ** MemLog2;
   localparam logic [OffW-1:0] LastOff = OffW'(BurstLen - 1);

   typedef enum logic [0:0] {
      StIdle,
      StBurst
   } state_e;

   state_e              state_q, state_d;
   logic [OffW-1:0]     beat_q, beat_d;
   logic [BlkW-1:0]     blk_q, blk_d;

   logic [MemLog2-1:0]  req_word;
   logic                accept;
   logic                wr_accept;
   logic                rd_accept;

   logic                issue_valid;
   logic [MemLog2-1:0]  issue_word;
   logic [OffW-1:0]     issue_off;
   logic                issue_last;
   logic [15:0]         issue_data;

   logic [15:0]         mem_q [Words];

   logic [Latency-1:0]  pipe_valid_q;
   logic [15:0]         pipe_data_q [Latency];
   logic [OffW-1:0]     pipe_off_q [Latency];
   logic [Latency-1:0]  pipe_last_q;

   // Byte lane select is meaningless for a word-wide array.
   logic                unused_addr_bit;
   assign unused_addr_bit = req_addr_i[0];

   // Word address wraps naturally by dropping the upper byte-address bits.
   assign req_word    = req_addr_i[MemLog2:1];
   assign req_ready_o = (state_q == StIdle);
   assign accept      = req_valid_i & req_ready_o;
   assign wr_accept   = accept & req_wr_i;
   assign rd_accept   = accept & ~req_wr_i;

   // Next-state and issue selection: a single read issues in its accept cycle, a burst issues
   // beat 0 in its accept cycle and the remaining beats from the BURST state.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      blk_d       = blk_q;
      issue_valid = 1'b0;
      issue_word  = req_word;
      issue_off   = req_word[OffW-1:0];
      issue_last  = 1'b1;
      case (state_q)
         StIdle: begin
            if (rd_accept) begin
               issue_valid = 1'b1;
               if (req_burst_i) begin
                  // Block-aligned order, not critical-word-first.
                  issue_word = {req_word[MemLog2-1:OffW], {OffW{1'b0}}};
                  issue_off  = '0;
                  issue_last = 1'b0;
                  blk_d      = req_word[MemLog2-1:OffW];
                  beat_d     = OffW'(1);
                  state_d    = StBurst;
               end
            end
         end
         StBurst: begin
            issue_valid = 1'b1;
            issue_word  = {blk_q, beat_q};
            issue_off   = beat_q;
            issue_last  = (beat_q == LastOff);
            beat_d      = beat_q + OffW'(1);
            if (beat_q == LastOff) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM and burst address registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         beat_q  <= '0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         blk_q   <= blk_d;
      end
   end

   // Backing array; contents survive reset, writes are suppressed while reset is asserted.
   always_ff @(posedge clk_i) begin
      if (rst_ni && wr_accept) begin
         mem_q[req_word] <= req_data_i;
      end
   end

   // Array is sampled in the issue cycle; no write can land during a burst, so the block is
   // a consistent snapshot.
   assign issue_data = mem_q[issue_word];

   for (genvar k = 0; k < Latency; k++) begin : g_pipe
      logic            in_valid;
      logic [15:0]     in_data;
      logic [OffW-1:0] in_off;
      logic            in_last;

      if (k == 0) begin : g_head
         assign in_valid = issue_valid;
         assign in_data  = issue_data;
         assign in_off   = issue_off;
         assign in_last  = issue_last;
      end else begin : g_tail
         assign in_valid = pipe_valid_q[k-1];
         assign in_data  = pipe_data_q[k-1];
         assign in_off   = pipe_off_q[k-1];
         assign in_last  = pipe_last_q[k-1];
      end

      // One pipe stage; payload only moves with a valid beat, so the outputs hold between beats.
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            pipe_valid_q[k] <= 1'b0;
            pipe_data_q[k]  <= '0;
            pipe_off_q[k]   <= '0;
            pipe_last_q[k]  <= 1'b0;
         end else begin
            pipe_valid_q[k] <= in_valid;
            if (in_valid) begin
               pipe_data_q[k] <= in_data;
               pipe_off_q[k]  <= in_off;
               pipe_last_q[k] <= in_last;
            end
         end
      end
   end

   assign resp_valid_o  = pipe_valid_q[Latency-1];
   assign resp_data_o   = pipe_data_q[Latency-1];
   assign resp_offset_o = pipe_off_q[Latency-1];
   assign resp_last_o   = pipe_last_q[Latency-1];
   assign busy_o        = (state_q == StBurst) | (|pipe_valid_q);

endmodule

// File: tb/tb_fill_mem_responder.sv
// Bench for fill_mem_responder: directed scenarios followed by random traffic, all checked
// every cycle against a transaction-level model (word array plus a queue of due beats).
module tb_fill_mem_responder;

   localparam int LAT = 4;
   localparam int BL  = 8;

   logic        clk;
   logic        rst_ni;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic        req_burst;
   logic [15:0] req_addr;
   logic [15:0] req_data;
   logic        resp_valid;
   logic [15:0] resp_data;
   logic [2:0]  resp_offset;
   logic        resp_last;
   logic        busy;

   fill_mem_responder #(
      .Latency  (LAT),
      .BurstLen (BL),
      .MemLog2  (15)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_wr_i      (req_wr),
      .req_burst_i   (req_burst),
      .req_addr_i    (req_addr),
      .req_data_i    (req_data),
      .resp_valid_o  (resp_valid),
      .resp_data_o   (resp_data),
      .resp_offset_o (resp_offset),
      .resp_last_o   (resp_last),
      .busy_o        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          due;
      logic [15:0] data;
      logic [2:0]  off;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [15:0] mem_m [32768];
   int          cyc      = 0;
   int          ready_at = 0;
   int          checks   = 0;
   int          errors   = 0;
   bit          chk_rst  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      bit exp_busy;
      bit exp_v;
      exp_busy = 1'b0;
      foreach (exp_q[i]) begin
         if (exp_q[i].due - LAT < cyc && cyc <= exp_q[i].due) exp_busy = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(cyc >= ready_at));
      check("busy", 32'(busy), 32'(exp_busy));
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("resp_valid", 32'(resp_valid), 32'(exp_v));
      if (exp_v) begin
         check("resp_data", 32'(resp_data), 32'(exp_q[0].data));
         check("resp_offset", 32'(resp_offset), 32'(exp_q[0].off));
         check("resp_last", 32'(resp_last), 32'(exp_q[0].last));
         void'(exp_q.pop_front());
      end
      if (chk_rst) begin
         check("rst_resp_data", 32'(resp_data), 32'h0);
         check("rst_resp_offset", 32'(resp_offset), 32'h0);
         check("rst_resp_last", 32'(resp_last), 32'h0);
         chk_rst = 1'b0;
      end
   endtask

   // Model of one accepted request in cycle cyc.
   task automatic model_accept(input bit wr, input bit b, input logic [15:0] a,
                               input logic [15:0] d);
      logic [14:0] word;
      logic [14:0] idx;
      int          base;
      beat_t       bt;
      word = a[15:1];
      if (wr) begin
         mem_m[word] = d;
      end else if (b) begin
         base = int'(word) / BL * BL;
         for (int i = 0; i < BL; i++) begin
            idx     = 15'(base + i);
            bt.due  = cyc + i + LAT;
            bt.data = mem_m[idx];
            bt.off  = 3'(i);
            bt.last = (i == BL - 1);
            exp_q.push_back(bt);
         end
         ready_at = cyc + BL;
      end else begin
         bt.due  = cyc + LAT;
         bt.data = mem_m[word];
         bt.off  = 3'(int'(word) % BL);
         bt.last = 1'b1;
         exp_q.push_back(bt);
      end
   endtask

   task automatic tick(input bit rn, input bit v, input bit wr, input bit b,
                       input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      check_outputs();
      rst_ni    = rn;
      req_valid = v;
      req_wr    = wr;
      req_burst = b;
      req_addr  = a;
      req_data  = d;
      if (!rn) begin
         exp_q.delete();
         ready_at = cyc + 1;
         chk_rst  = 1'b1;
      end else if (v && cyc >= ready_at) begin
         model_accept(wr, b, a, d);
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic wr_w(input logic [15:0] a, input logic [15:0] d);
      tick(1'b1, 1'b1, 1'b1, 1'b0, a, d);
   endtask

   task automatic rd_w(input logic [15:0] a);
      tick(1'b1, 1'b1, 1'b0, 1'b0, a, 16'h0);
   endtask

   task automatic bst(input logic [15:0] a);
      tick(1'b1, 1'b1, 1'b0, 1'b1, a, 16'h0);
   endtask

   initial begin
      logic [15:0] ra;
      int          r;
      rst_ni    = 1'b0;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_burst = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      repeat (2) @(posedge clk);
      chk_rst = 1'b1;

      // Reset holds off writes even with a valid request present.
      wr_w(16'h0020, 16'h5555);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'hDEAD);
      rd_w(16'h0020);
      idle(LAT + 1);

      // Write then read-after-write.
      wr_w(16'h0010, 16'h1234);
      rd_w(16'h0010);
      idle(LAT + 2);

      // Preload a block and burst from mid-block; write attempts during the burst are refused.
      for (int i = 0; i < BL; i++) wr_w(16'(16'h0040 + 2 * i), 16'(16'hA000 + i));
      bst(16'h0046);
      for (int i = 0; i < BL - 1; i++) wr_w(16'h0042, 16'hBEEF);
      idle(LAT + 1);

      // Back-to-back single reads.
      rd_w(16'h0040);
      rd_w(16'h0042);
      rd_w(16'h004A);
      rd_w(16'h004E);
      idle(LAT + 2);

      // Reset in the middle of a burst, then the same block again.
      for (int i = 0; i < BL; i++) wr_w(16'(16'h0080 + 2 * i), 16'(16'hC0DE ^ i));
      bst(16'h0080);
      idle(5);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      idle(3);
      bst(16'h008C);
      idle(BL + LAT + 1);

      // Top of the address space.
      for (int i = 0; i < BL; i++) wr_w(16'(16'hFFF0 + 2 * i), 16'(16'h7000 + 16'h11 * i));
      wr_w(16'h0000, 16'h0F0F);
      rd_w(16'hFFFE);
      rd_w(16'hFFFF);
      idle(LAT + 1);
      bst(16'hFFF0);
      idle(BL + LAT + 1);
      bst(16'hFFFA);
      rd_w(16'h0000);
      idle(BL + LAT + 1);

      // Random traffic inside a preloaded window.
      for (int i = 0; i < 64; i++) wr_w(16'(16'h0200 + 2 * i), 16'($urandom));
      for (int i = 0; i < 400; i++) begin
         r  = int'($urandom_range(0, 99));
         ra = 16'(16'h0200 + $urandom_range(0, 127));
         if (r < 35)      tick(1'b1, 1'b0, 1'($urandom), 1'($urandom), ra, 16'($urandom));
         else if (r < 60) rd_w(ra);
         else if (r < 78) tick(1'b1, 1'b1, 1'b1, 1'($urandom), ra, 16'($urandom));
         else if (r < 98) bst(ra);
         else             tick(1'b0, 1'($urandom), 1'b0, 1'b0, ra, 16'h0);
      end
      idle(BL + LAT + 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
